// File: rtl/turfio_bus_master.sv
// TURFIO-side initiator for the byte-serial TURF register bus (nCS / WnR / 8-bit DIO).
// Turns single 32-bit read/write requests into address + 4 data bytes, LSB first.
module turfio_bus_master #(
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned GAP        = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdat_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdat_o,
  output logic        nCS_o,
  output logic        WnR_o,
  output logic [7:0]  dio_o,
  output logic        dio_oe_o,
  input  logic [7:0]  dio_i
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StAddr  = 3'd1;
  localparam logic [2:0] StWdata = 3'd2;
  localparam logic [2:0] StTurn  = 3'd3;
  localparam logic [2:0] StRdata = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [2:0] TurnLast = 3'(TURNAROUND - 1);
  localparam logic [2:0] GapLast  = 3'(GAP - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] wdat_q, wdat_d;
  logic [23:0] rbuf_q, rbuf_d;
  logic [31:0] rdat_q, rdat_d;
  logic [7:0]  dio_q, dio_d;
  logic        ncs_q, ncs_d;
  logic        wnr_q, wnr_d;
  logic        oe_q, oe_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rbuf_d  = rbuf_q;
    rdat_d  = rdat_q;
    dio_d   = dio_q;

    case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = StAddr;
          we_d    = we_i;
          wdat_d  = wdat_i;
          dio_d   = addr_i;
        end
      end
      StAddr: begin
        cnt_d   = 3'd0;
        state_d = we_q ? StWdata : StTurn;
      end
      StWdata: begin
        if (cnt_q == 3'd3) begin
          state_d = StDone;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StTurn: begin
        if (cnt_q == TurnLast) begin
          state_d = StRdata;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StRdata: begin
        case (cnt_q[1:0])
          2'd0:    rbuf_d[7:0]   = dio_i;
          2'd1:    rbuf_d[15:8]  = dio_i;
          2'd2:    rbuf_d[23:16] = dio_i;
          default: ;
        endcase
        if (cnt_q == 3'd3) begin
          // Last byte goes straight into rdat so it is valid with ack.
          state_d = StDone;
          cnt_d   = 3'd0;
          rdat_d  = {dio_i, rbuf_q};
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    if (state_d == StWdata) begin
      case (cnt_d[1:0])
        2'd0:    dio_d = wdat_q[7:0];
        2'd1:    dio_d = wdat_q[15:8];
        2'd2:    dio_d = wdat_q[23:16];
        default: dio_d = wdat_q[31:24];
      endcase
    end

    ncs_d  = !(state_d inside {StAddr, StWdata, StTurn, StRdata});
    wnr_d  = !(state_d inside {StTurn, StRdata});
    oe_d   = state_d inside {StAddr, StWdata};
    busy_d = (state_d != StIdle);
    ack_d  = (state_d == StDone) && (state_q != StDone);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      wdat_q  <= 32'd0;
      rbuf_q  <= 24'd0;
      rdat_q  <= 32'd0;
      dio_q   <= 8'd0;
      ncs_q   <= 1'b1;
      wnr_q   <= 1'b1;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      rbuf_q  <= rbuf_d;
      rdat_q  <= rdat_d;
      dio_q   <= dio_d;
      ncs_q   <= ncs_d;
      wnr_q   <= wnr_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign ack_o    = ack_q;
  assign rdat_o   = rdat_q;
  assign nCS_o    = ncs_q;
  assign WnR_o    = wnr_q;
  assign dio_o    = dio_q;
  assign dio_oe_o = oe_q;

endmodule

// File: tb/tb_turfio_bus_master.sv
// Bench for turfio_bus_master: two instances (default and TURNAROUND=3/GAP=2), each checked
// cycle by cycle against an expected bus waveform derived from the transaction timeline.
module tb_turfio_bus_master;

  localparam int TA0 = 1;
  localparam int GP0 = 1;
  localparam int TA1 = 3;
  localparam int GP1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_s, we_s, busy_s, ack_s, ncs_s, wnr_s, oe_s;
  logic [7:0]  addr_s [2];
  logic [31:0] wdat_s [2];
  logic [7:0]  dio_in [2];
  logic [7:0]  dio_out [2];
  logic [31:0] rdat_s [2];
  logic [31:0] exp_rdat [2];

  int checks = 0;
  int errors = 0;

  turfio_bus_master #(.TURNAROUND(TA0), .GAP(GP0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_s[0]), .we_i(we_s[0]), .addr_i(addr_s[0]),
    .wdat_i(wdat_s[0]), .busy_o(busy_s[0]), .ack_o(ack_s[0]), .rdat_o(rdat_s[0]),
    .nCS_o(ncs_s[0]), .WnR_o(wnr_s[0]), .dio_o(dio_out[0]), .dio_oe_o(oe_s[0]),
    .dio_i(dio_in[0])
  );

  turfio_bus_master #(.TURNAROUND(TA1), .GAP(GP1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_s[1]), .we_i(we_s[1]), .addr_i(addr_s[1]),
    .wdat_i(wdat_s[1]), .busy_o(busy_s[1]), .ack_o(ack_s[1]), .rdat_o(rdat_s[1]),
    .nCS_o(ncs_s[1]), .WnR_o(wnr_s[1]), .dio_o(dio_out[1]), .dio_oe_o(oe_s[1]),
    .dio_i(dio_in[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // The master must never drive DIO while the responder owns it.
  always @(negedge clk) begin
    checks++;
    assert (!(oe_s[0] && !wnr_s[0]) && !(oe_s[1] && !wnr_s[1])) else begin
      errors++;
      $error("FAIL bus_contention observed oe=%b wnr=%b expected no oe with wnr=0",
             oe_s, wnr_s);
    end
  end

  task automatic chk_outs(input int d, input int c, input logic e_ncs, input logic e_wnr,
                          input logic e_oe, input logic [7:0] e_dio, input logic e_ack,
                          input logic e_busy);
    chk($sformatf("d%0d c%0d nCS", d, c), 32'(ncs_s[d]), 32'(e_ncs));
    chk($sformatf("d%0d c%0d WnR", d, c), 32'(wnr_s[d]), 32'(e_wnr));
    chk($sformatf("d%0d c%0d dio_oe", d, c), 32'(oe_s[d]), 32'(e_oe));
    chk($sformatf("d%0d c%0d dio", d, c), 32'(dio_out[d]), 32'(e_dio));
    chk($sformatf("d%0d c%0d ack", d, c), 32'(ack_s[d]), 32'(e_ack));
    chk($sformatf("d%0d c%0d busy", d, c), 32'(busy_s[d]), 32'(e_busy));
    chk($sformatf("d%0d c%0d rdat", d, c), rdat_s[d], exp_rdat[d]);
  endtask

  // Called during an IDLE cycle (just after a rising edge). Runs one transaction and ends
  // after checking the IDLE cycle that follows it. abort_at>0 resets the DUTs in that cycle.
  task automatic txn(input int d, input bit w, input logic [7:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input bit hold, input bit noise, input int abort_at);
    int ta = (d == 0) ? TA0 : TA1;
    int gp = (d == 0) ? GP0 : GP1;
    int b  = w ? 5 : 5 + ta;
    logic [7:0] last = w ? wd[31:24] : a;
    req_s[d] = 1'b1; we_s[d] = w; addr_s[d] = a; wdat_s[d] = wd;
    for (int c = 1; c <= b + gp + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk_outs(d, c, 1'b0, 1'b1, 1'b1, a, 1'b0, 1'b1);
      else if (c <= b) begin
        if (w) chk_outs(d, c, 1'b0, 1'b1, 1'b1, wd[8*(c-2) +: 8], 1'b0, 1'b1);
        else   chk_outs(d, c, 1'b0, 1'b0, 1'b0, a, 1'b0, 1'b1);
      end else if (c <= b + gp) begin
        if (!w && c == b + 1) exp_rdat[d] = rd;
        chk_outs(d, c, 1'b1, 1'b1, 1'b0, last, (c == b + 1), 1'b1);
      end else chk_outs(d, c, 1'b1, 1'b1, 1'b0, last, 1'b0, 1'b0);

      if (c == abort_at) begin
        rst_n = 1'b0;
        req_s[d] = 1'b0;
        #1;
        exp_rdat[0] = 32'd0;
        exp_rdat[1] = 32'd0;
        chk_outs(d, 100 + c, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_outs(d, 200 + c, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        return;
      end

      if (hold) req_s[d] = 1'b1;
      else if (noise && c >= b - 3 && c <= b) begin
        req_s[d] = 1'b1; we_s[d] = 1'b1;
        addr_s[d] = 8'($urandom); wdat_s[d] = $urandom;
      end else req_s[d] = 1'b0;
      dio_in[d] = (!w && c >= b - 3 && c <= b) ? rd[8*(c-(b-3)) +: 8] : 8'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_s = '0; we_s = '0;
    for (int i = 0; i < 2; i++) begin
      addr_s[i] = '0; wdat_s[i] = '0; dio_in[i] = '0; exp_rdat[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk_outs(i, 0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: write, read with a request pulsed mid-read, back-to-back read then write.
    txn(0, 1'b1, 8'h1C, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 0);
    txn(0, 1'b0, 8'h05, 32'h0, 32'h12345678, 1'b0, 1'b1, 0);
    txn(0, 1'b0, 8'h33, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 0);
    txn(0, 1'b1, 8'h44, 32'h01020304, 32'h0, 1'b0, 1'b0, 0);
    // Reset in the third write-byte cycle, then a fresh read.
    txn(0, 1'b1, 8'h55, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 4);
    @(posedge clk); #1;
    txn(0, 1'b0, 8'h66, 32'h0, 32'h89ABCDEF, 1'b0, 1'b0, 0);

    for (int n = 0; n < 10; n++)
      txn(0, 1'($urandom), 8'($urandom), $urandom, $urandom, (n < 9) && 1'($urandom),
          1'($urandom), 0);

    // Wider turnaround/gap instance.
    txn(1, 1'b0, 8'h05, 32'h0, 32'h12345678, 1'b0, 1'b0, 0);
    txn(1, 1'b0, 8'h77, 32'h0, 32'h0BADCAFE, 1'b1, 1'b0, 0);
    txn(1, 1'b1, 8'h1C, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 0);
    for (int n = 0; n < 10; n++)
      txn(1, 1'($urandom), 8'($urandom), $urandom, $urandom, (n < 9) && 1'($urandom),
          1'($urandom), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
